// File: rtl/register_file.sv
// register_file: MIPS general-purpose register file, 32 x 32-bit by default.
// Two combinational read ports, one synchronous write port, $0 hardwired to zero,
// plus a committed-write counter for debug/trace.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic [CNT_WIDTH-1:0]  write_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [CNT_WIDTH-1:0]  count;
  logic                  write_en;

  // A write only commits when enabled and not aimed at the hardwired-zero register;
  // an unknown index evaluates to unknown here, so no entry gets written in simulation.
  assign write_en = RegWrite && (WriteReg != '0);

  // Storage and counter: cleared asynchronously, updated once per committed write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      count <= '0;
    end else if (write_en) begin
      regs[WriteReg] <= WriteData;
      count          <= count + CNT_ONE;
    end
  end

  // Read port 1: index 0 always reads zero; optional forwarding of the in-flight write.
  always_comb begin
    ReadData1 = regs[ReadReg1];
    if (ReadReg1 == '0) begin
      ReadData1 = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (write_en && (WriteReg == ReadReg1)) begin
      ReadData1 = WriteData;
    end
`endif
  end

  // Read port 2: same rules as port 1 so identical indices always give identical data.
  always_comb begin
    ReadData2 = regs[ReadReg2];
    if (ReadReg2 == '0) begin
      ReadData2 = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (write_en && (WriteReg == ReadReg2)) begin
      ReadData2 = WriteData;
    end
`endif
  end

  assign write_count = count;

endmodule
